// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit: Moore FSM driving datapath selects, enables and ALUControl.
// Latency: outputs are combinational from state (PCWrite also from Zero); state advances each clk.
// Backpressure: none; one state step per cycle, reset forces FETCH asynchronously.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl
);

    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECR    = 4'd6;
    localparam logic [3:0] ALUWB    = 4'd7;
    localparam logic [3:0] EXECI    = 4'd8;
    localparam logic [3:0] JAL      = 4'd9;
    localparam logic [3:0] BEQ      = 4'd10;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    logic [3:0] state;
    logic [3:0] next_state;
    logic [1:0] alu_op;
    logic       branch;
    logic       pc_update;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= FETCH;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:    next_state = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = EXECR;
                    OP_ITYPE:     next_state = EXECI;
                    OP_JAL:       next_state = JAL;
                    OP_BEQ:       next_state = BEQ;
                    // Illegal opcodes are skipped; PC already advanced in FETCH.
                    default:      next_state = FETCH;
                endcase
            end
            MEMADR:   next_state = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  next_state = MEMWB;
            EXECR:    next_state = ALUWB;
            EXECI:    next_state = ALUWB;
            JAL:      next_state = ALUWB;
            MEMWB:    next_state = FETCH;
            MEMWRITE: next_state = FETCH;
            ALUWB:    next_state = FETCH;
            BEQ:      next_state = FETCH;
            default:  next_state = FETCH;
        endcase
    end

    always_comb begin
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        RegWrite  = 1'b0;
        alu_op    = 2'b00;
        branch    = 1'b0;
        pc_update = 1'b0;
        case (state)
            FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                pc_update = 1'b1;
            end
            // Branch/jump target is precomputed here and held in ALUOut.
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            EXECR: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
            end
            EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
            end
            ALUWB: begin
                RegWrite = 1'b1;
            end
            JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                branch  = 1'b1;
            end
            default: begin
                RegWrite = 1'b0;
            end
        endcase
    end

    assign PCWrite = (branch & Zero) | pc_update;

    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            2'b00: ALUControl = 3'b000;
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    // Only R-type with funct7b5 subtracts; addi ignores bit 30.
                    3'b000:  ALUControl = ({op[5], funct7b5} == 2'b11) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b010;
                    3'b111:  ALUControl = 3'b011;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_LW, OP_ITYPE: ImmSrc = 2'b00;
            OP_SW:           ImmSrc = 2'b01;
            OP_BEQ:          ImmSrc = 2'b10;
            OP_JAL:          ImmSrc = 2'b11;
            default:         ImmSrc = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed scoreboard bench for multicycle_controller: expected per-cycle state and outputs queued, then popped and compared.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       RegWrite;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .RegWrite   (RegWrite),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic       rw;
        logic [1:0] rs;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] imm;
        logic [2:0] alu;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    seq[$];
    int    ncmp  = 0;
    int    nfail = 0;

    // Expected outputs for a given state under the current op/funct3/funct7b5/Zero.
    function automatic exp_t model(input int st_i);
        exp_t       e;
        logic [1:0] aluop;
        logic       br;
        logic       pcu;
        e     = '0;
        aluop = 2'b00;
        br    = 1'b0;
        pcu   = 1'b0;
        e.st  = st_i[3:0];
        case (st_i)
            0:  begin e.irw = 1; e.sb = 2'b10; e.rs = 2'b10; pcu = 1; end
            1:  begin e.sa = 2'b01; e.sb = 2'b01; end
            2:  begin e.sa = 2'b10; e.sb = 2'b01; end
            3:  begin e.adr = 1; end
            4:  begin e.rs = 2'b01; e.rw = 1; end
            5:  begin e.adr = 1; e.mw = 1; end
            6:  begin e.sa = 2'b10; aluop = 2'b10; end
            7:  begin e.rw = 1; end
            8:  begin e.sa = 2'b10; e.sb = 2'b01; aluop = 2'b10; end
            9:  begin e.sa = 2'b01; e.sb = 2'b10; pcu = 1; end
            10: begin e.sa = 2'b10; aluop = 2'b01; br = 1; end
            default: e = '0;
        endcase
        e.pcw = (br & Zero) | pcu;
        if (aluop == 2'b01)
            e.alu = 3'b001;
        else if (aluop == 2'b10) begin
            if (funct3 == 3'b000)      e.alu = (op[5] && funct7b5) ? 3'b001 : 3'b000;
            else if (funct3 == 3'b010) e.alu = 3'b101;
            else if (funct3 == 3'b110) e.alu = 3'b010;
            else if (funct3 == 3'b111) e.alu = 3'b011;
            else                       e.alu = 3'b000;
        end else
            e.alu = 3'b000;
        if (op == 7'b0100011)      e.imm = 2'b01;
        else if (op == 7'b1100011) e.imm = 2'b10;
        else if (op == 7'b1101111) e.imm = 2'b11;
        else                       e.imm = 2'b00;
        return e;
    endfunction

    task automatic chk(input string t, input logic [3:0] got, input logic [3:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", t, got, exp);
        end
    endtask

    // Drive one instruction's fields, queue expectations for seq, then compare cycle by cycle.
    task automatic run(input string tag, input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input logic z);
        exp_t  e;
        string t;
        op       = o;
        funct3   = f3;
        funct7b5 = f7;
        Zero     = z;
        for (int i = 0; i < seq.size(); i++) begin
            sb_q.push_back(model(seq[i]));
            tag_q.push_back($sformatf("%s.c%0d", tag, i));
        end
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            chk({t, ".state"},      dut.state,          e.st);
            chk({t, ".PCWrite"},    {3'b0, PCWrite},    {3'b0, e.pcw});
            chk({t, ".AdrSrc"},     {3'b0, AdrSrc},     {3'b0, e.adr});
            chk({t, ".MemWrite"},   {3'b0, MemWrite},   {3'b0, e.mw});
            chk({t, ".IRWrite"},    {3'b0, IRWrite},    {3'b0, e.irw});
            chk({t, ".RegWrite"},   {3'b0, RegWrite},   {3'b0, e.rw});
            chk({t, ".ResultSrc"},  {2'b0, ResultSrc},  {2'b0, e.rs});
            chk({t, ".ALUSrcA"},    {2'b0, ALUSrcA},    {2'b0, e.sa});
            chk({t, ".ALUSrcB"},    {2'b0, ALUSrcB},    {2'b0, e.sb});
            chk({t, ".ImmSrc"},     {2'b0, ImmSrc},     {2'b0, e.imm});
            chk({t, ".ALUControl"}, {1'b0, ALUControl}, {1'b0, e.alu});
            if (sb_q.size() > 0) begin
                @(posedge clk);
                #2;
            end
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        op       = 7'b0;
        funct3   = 3'b0;
        funct7b5 = 1'b0;
        Zero     = 1'b0;
        #1;
        seq = '{0};
        run("reset", 7'b0000000, 3'b000, 1'b0, 1'b0);
        reset = 1'b0;

        seq = '{0, 1, 2, 3, 4, 0};
        run("lw", 7'b0000011, 3'b010, 1'b0, 1'b0);
        seq = '{0, 1, 2, 5, 0};
        run("sw", 7'b0100011, 3'b010, 1'b0, 1'b0);
        seq = '{0, 1, 6, 7, 0};
        run("sub", 7'b0110011, 3'b000, 1'b1, 1'b0);
        run("add", 7'b0110011, 3'b000, 1'b0, 1'b0);
        run("slt", 7'b0110011, 3'b010, 1'b0, 1'b0);
        run("or", 7'b0110011, 3'b110, 1'b0, 1'b0);
        run("and", 7'b0110011, 3'b111, 1'b1, 1'b0);
        run("sll", 7'b0110011, 3'b001, 1'b0, 1'b0);
        seq = '{0, 1, 8, 7, 0};
        run("addi_f7", 7'b0010011, 3'b000, 1'b1, 1'b0);
        run("ori", 7'b0010011, 3'b110, 1'b0, 1'b0);
        seq = '{0, 1, 10, 0};
        run("beq_taken", 7'b1100011, 3'b000, 1'b0, 1'b1);
        run("beq_not", 7'b1100011, 3'b000, 1'b0, 1'b0);
        seq = '{0, 1, 9, 7, 0};
        run("jal", 7'b1101111, 3'b000, 1'b0, 1'b1);
        seq = '{0, 1, 0};
        run("illegal", 7'b1111111, 3'b000, 1'b1, 1'b1);

        // Reset pulse in the middle of MEMREAD must return to FETCH without a clock edge.
        seq = '{0, 1, 2, 3};
        run("lw_pre", 7'b0000011, 3'b010, 1'b0, 1'b0);
        reset = 1'b1;
        seq = '{0};
        run("rst_mid", 7'b0000011, 3'b010, 1'b0, 1'b0);
        reset = 1'b0;
        seq = '{0, 1, 2, 3, 4, 0};
        run("lw_post", 7'b0000011, 3'b010, 1'b0, 1'b0);

        // Reset during MEMWRITE drops the pending write immediately.
        seq = '{0, 1, 2, 5};
        run("sw_pre", 7'b0100011, 3'b010, 1'b0, 1'b0);
        reset = 1'b1;
        seq = '{0};
        run("rst_sw", 7'b0100011, 3'b010, 1'b0, 1'b0);
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
